// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the encoder and its packing logic.
// Pure declarations; no timing.
// No flow control here; handshakes live in the top level.
package imm_encoder_pkg;

    // ImmSel format codes, shared with the immediate generator and control decoder.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Request captured in stage 1.
    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
    } enc_req_t;

    // Result captured in stage 2.
    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_rsp_t;

    // True when v is a sign extension of its bits [msb:0], i.e. bits
    // [31:msb] are all equal. Called with constant msb only.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] t;
        t = $signed(v) >>> msb;
        return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Scatters an immediate into the selected RISC-V format and flags unencodable values.
// Latency: purely combinational.
// No flow control; the surrounding pipeline decides when the result is captured.
module imm_encoder_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  ImmSel,
    input  logic [31:0] Imm,
    input  logic [31:0] Base,
    output logic [31:0] Inst,
    output logic        ImmErr
);

    // Start from Base and overwrite only the immediate fields of the chosen format.
    // Out-of-range values are still packed (truncated) so the word is observable.
    always_comb begin
        Inst   = Base;
        ImmErr = 1'b0;
        case (ImmSel)
            IMM_I: begin
                Inst[31:20] = Imm[11:0];
                ImmErr      = !fits_signed(Imm, 11);
            end
            IMM_S: begin
                Inst[31:25] = Imm[11:5];
                Inst[11:7]  = Imm[4:0];
                ImmErr      = !fits_signed(Imm, 11);
            end
            IMM_B: begin
                Inst[31]    = Imm[12];
                Inst[30:25] = Imm[10:5];
                Inst[11:8]  = Imm[4:1];
                Inst[7]     = Imm[11];
                ImmErr      = !fits_signed(Imm, 12) || Imm[0];
            end
            IMM_U: begin
                Inst[31:12] = Imm[31:12];
                ImmErr      = (Imm[11:0] != 12'h000);
            end
            IMM_J: begin
                Inst[31]    = Imm[20];
                Inst[30:21] = Imm[10:1];
                Inst[20]    = Imm[11];
                Inst[19:12] = Imm[19:12];
                ImmErr      = !fits_signed(Imm, 20) || Imm[0];
            end
            default: begin
                // Reserved selector: pass Base through untouched but flag it.
                Inst   = Base;
                ImmErr = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage streaming immediate encoder with saturating handshake/error counters.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle throughput.
// Backpressure: combinational ready chain from out_ready to in_ready; full stall holds both stages.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSel,
    input  logic [31:0]      Imm,
    input  logic [31:0]      Base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Inst,
    output logic             ImmErr,
    input  logic             clr,
    output logic [CNT_W-1:0] EncCount,
    output logic [CNT_W-1:0] ErrCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid_q, s1_valid_d;
    enc_req_t         s1_req_q,   s1_req_d;
    logic             s2_valid_q, s2_valid_d;
    enc_rsp_t         s2_rsp_q,   s2_rsp_d;
    logic [CNT_W-1:0] enc_cnt_q,  enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic     s1_adv;
    logic     s2_adv;
    logic     in_hs;
    logic     out_hs;
    enc_rsp_t pack_rsp;

    // A stage may move when it is empty or the stage after it is moving.
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        in_hs  = in_valid && s1_adv;
        out_hs = s2_valid_q && out_ready;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign Inst      = s2_rsp_q.inst;
    assign ImmErr    = s2_rsp_q.err;

    imm_encoder_pack u_pack (
        .ImmSel (s1_req_q.sel),
        .Imm    (s1_req_q.imm),
        .Base   (s1_req_q.base),
        .Inst   (pack_rsp.inst),
        .ImmErr (pack_rsp.err)
    );

    // Stage 1 captures the raw request on an input handshake.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_hs) begin
            s1_req_d.sel  = ImmSel;
            s1_req_d.imm  = Imm;
            s1_req_d.base = Base;
        end
    end

    // Stage 2 captures the packed word; it only changes when it advances,
    // so a stalled output stays stable.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_rsp_d   = s2_rsp_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_rsp_d = pack_rsp;
            end
        end
    end

    // Counters step on output handshakes, stick at all-ones, and clr wins.
    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            enc_cnt_d = '0;
            err_cnt_d = '0;
        end else if (out_hs) begin
            if (enc_cnt_q != CNT_MAX) begin
                enc_cnt_d = enc_cnt_q + CNT_ONE;
            end
            if (s2_rsp_q.err && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    assign EncCount = enc_cnt_q;
    assign ErrCount = err_cnt_q;

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rsp_q   <= '0;
            enc_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            s2_rsp_q   <= s2_rsp_d;
            enc_cnt_q  <= enc_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed vector table, backpressure, reset, counter and random round-trip checks.
// Counters use a 4-bit width so saturation is reachable quickly.
// Outputs are sampled 1 time unit after the rising edge or on the falling edge.
module tb_imm_encoder;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ImmSel;
    logic [31:0]   Imm;
    logic [31:0]   Base;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   Inst;
    logic          ImmErr;
    logic          clr;
    logic [CW-1:0] EncCount;
    logic [CW-1:0] ErrCount;

    int n_cmp = 0;
    int n_bad = 0;

    imm_encoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSel    (ImmSel),
        .Imm       (Imm),
        .Base      (Base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Inst      (Inst),
        .ImmErr    (ImmErr),
        .clr       (clr),
        .EncCount  (EncCount),
        .ErrCount  (ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
    } req_t;

    vec_t vecs[14];
    req_t sb[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    // Independent immediate generator (decoder direction).
    function automatic logic [31:0] imm_gen(input logic [2:0] sel, input logic [31:0] i);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'h000};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Bits of the instruction word that carry the immediate, per format.
    function automatic logic [31:0] imm_mask(input logic [2:0] sel);
        case (sel)
            3'd0:    return 32'hFFF0_0000;
            3'd1:    return 32'hFE00_0F80;
            3'd2:    return 32'hFE00_0F80;
            3'd3:    return 32'hFFFF_F000;
            3'd4:    return 32'hFFFF_F000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return {{20{r[11]}}, r[11:0]};
            1:       return {{19{r[12]}}, r[12:1], 1'b0};
            2:       return {r[31:12], 12'h000};
            3:       return {{11{r[20]}}, r[20:1], 1'b0};
            default: return r;
        endcase
    endfunction

    initial begin
        int lat;
        int n_err_exp;
        int k;
        int n_out;
        logic acc;
        logic [31:0] exp_i;
        req_t rq;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
        vecs[1]  = '{3'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
        vecs[2]  = '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
        vecs[3]  = '{3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0};
        vecs[4]  = '{3'd1, 32'hFFFF_F800, 32'h0000_2023, 32'h8000_2023, 1'b0};
        vecs[5]  = '{3'd1, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1};
        vecs[6]  = '{3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
        vecs[7]  = '{3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
        vecs[8]  = '{3'd2, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1};
        vecs[9]  = '{3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
        vecs[10] = '{3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1};
        vecs[11] = '{3'd4, 32'h0000_0008, 32'h0000_006F, 32'h0080_006F, 1'b0};
        vecs[12] = '{3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
        vecs[13] = '{3'd6, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        ImmSel = 3'd0; Imm = 32'h0; Base = 32'h0;

        // Reset state.
        #12;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_immerr", {31'h0, ImmErr}, 32'h0);
        chk("rst_enc", {28'h0, EncCount}, 32'h0);
        chk("rst_err", {28'h0, ErrCount}, 32'h0);
        rst_n = 1'b1;

        // Directed table with free-flowing output.
        n_err_exp = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ImmSel = vecs[i].sel; Imm = vecs[i].imm; Base = vecs[i].base;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_inst", i), Inst, vecs[i].inst);
            chk($sformatf("v%0d_immerr", i), {31'h0, ImmErr}, {31'h0, vecs[i].err});
            if (vecs[i].err) n_err_exp++;
        end
        @(posedge clk);
        #1;
        chk("table_enc_count", {28'h0, EncCount}, 14);
        chk("table_err_count", {28'h0, ErrCount}, n_err_exp);

        // Backpressure: four I-format words, output stalled for 5 cycles.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        k = 0; n_out = 0;
        for (int cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (k < 4);
            ImmSel = 3'd0; Imm = k + 1; Base = 32'h0000_0013;
            #1;
            acc = in_valid && in_ready;
            if (cyc == 4) begin
                chk("bp_accepted", k, 2);
                chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            end
            if (cyc >= 3 && out_valid && !out_ready)
                chk("bp_hold_inst", Inst, 32'h0010_0013);
            if (out_valid && out_ready) begin
                exp_i = ((n_out + 1) << 20) | 32'h13;
                chk($sformatf("bp_order%0d", n_out), Inst, exp_i);
                n_out++;
            end
            @(posedge clk);
            if (acc) k++;
        end
        #1;
        in_valid = 1'b0;
        chk("bp_outputs", n_out, 4);
        chk("bp_enc_count", {28'h0, EncCount}, 4);

        // Random valid/ready soak with round-trip check.
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ImmSel = $urandom_range(0, 4);
            Imm    = rand_imm();
            Base   = $urandom;
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("soak_unexpected_out", 32'h1, 32'h0);
                end else begin
                    rq = sb.pop_front();
                    chk("soak_base_bits", Inst & ~imm_mask(rq.sel), rq.base & ~imm_mask(rq.sel));
                    chk("soak_err", {31'h0, ImmErr}, {31'h0, imm_gen(rq.sel, Inst) != rq.imm});
                end
            end
            if (in_valid && in_ready) sb.push_back('{ImmSel, Imm, Base});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            #1;
            if (out_valid) begin
                rq = sb.pop_front();
                chk("drain_base_bits", Inst & ~imm_mask(rq.sel), rq.base & ~imm_mask(rq.sel));
                chk("drain_err", {31'h0, ImmErr}, {31'h0, imm_gen(rq.sel, Inst) != rq.imm});
            end
            @(negedge clk);
        end
        chk("soak_left", sb.size(), 0);

        // Reset with two words in flight.
        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            in_valid = 1'b1; ImmSel = 3'd0; Imm = 32'h5; Base = 32'h13;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_enc", {28'h0, EncCount}, 32'h0);
        chk("rst_mid_err", {28'h0, ErrCount}, 32'h0);
        chk("rst_mid_out_valid2", {31'h0, out_valid}, 32'h0);

        // Saturation: 17 reserved-selector words through a 4-bit counter.
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            in_valid = 1'b1; ImmSel = 3'd5; Imm = 32'h0; Base = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_enc", {28'h0, EncCount}, 32'hF);
        chk("sat_err", {28'h0, ErrCount}, 32'hF);

        // clr coinciding with an output handshake.
        @(negedge clk);
        in_valid = 1'b1; ImmSel = 3'd0; Imm = 32'h1; Base = 32'h13;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("clr_out_valid", {31'h0, out_valid}, 32'h1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_enc", {28'h0, EncCount}, 32'h0);
        chk("clr_err", {28'h0, ErrCount}, 32'h0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_then_enc", {28'h0, EncCount}, 32'h1);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
